stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 168 ++++++++++++++++
 tb/tb_stage_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// MEM stage of the integer pipeline: bus handshake for loads/stores and the MEM/WB register.
// A legal access holds the pipeline in BUSY until the bus answers; bad accesses retire at once with an error pulse.
module stage_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_err
);

    localparam int DATA_W = 32;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [2:0]          funct3_p1;
    logic [1:0]          addr_lo_p1;
    logic [4:0]          rd_p1;
    logic                reg_write_p1;
    logic                mem_to_reg_p1;
    logic                is_load_p1;
    logic                mem_op, illegal, misaligned, bad_op, accept;

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_wdata(input logic [1:0] size, input logic [DATA_W-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                   input logic [2:0] f3, input logic [1:0] a);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = rdata[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign mem_op     = in_valid & (mem_read | mem_write);
    assign illegal    = mem_read ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                                 : (funct3[2] || funct3[1:0] == 2'b11);
    assign misaligned = (funct3[1:0] == 2'b01 && alu_result[0]) ||
                        (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    assign bad_op     = mem_op & (illegal | misaligned);
    assign accept     = mem_op & ~bad_op;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                stall = ~mem_ready;
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            misalign_err  <= 1'b0;
            funct3_p1     <= '0;
            addr_lo_p1    <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            is_load_p1    <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            case (state)
                // EX/MEM -> bus request, or direct retire into MEM/WB
                IDLE: begin
                    if (accept) begin
                        mem_req       <= 1'b1;
                        mem_we        <= ~mem_read;
                        mem_addr      <= {alu_result[31:2], 2'b00};
                        mem_wdata     <= mem_read ? '0 : store_wdata(funct3[1:0], store_data);
                        mem_wstrb     <= mem_read ? 4'b0000 : store_strb(funct3[1:0], alu_result[1:0]);
                        funct3_p1     <= funct3;
                        addr_lo_p1    <= alu_result[1:0];
                        rd_p1         <= rd_in;
                        reg_write_p1  <= reg_write_in;
                        mem_to_reg_p1 <= mem_to_reg_in;
                        is_load_p1    <= mem_read;
                    end else if (in_valid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        wb_rd        <= rd_in;
                        wb_reg_write <= reg_write_in & ~mem_op;
                        misalign_err <= mem_op;
                    end
                end
                // bus response -> MEM/WB
                BUSY: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_addr     <= '0;
                        mem_wdata    <= '0;
                        mem_wstrb    <= '0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_p1;
                        wb_reg_write <= is_load_p1 & reg_write_p1 & (rd_p1 != 5'd0);
                        wb_data      <= mem_to_reg_p1 ? load_ext(mem_rdata, funct3_p1, addr_lo_p1)
                                                      : {mem_addr[31:2], addr_lo_p1};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: expected writebacks queued at issue, popped when wb_valid appears.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic        reg_write_in, mem_to_reg_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    stage_mem dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .rd_in(rd_in), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; alu_result = 0; store_data = 0;
        rd_in = 0; funct3 = 0; reg_write_in = 0; mem_to_reg_in = 0;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic rw);
        in_valid = 1; mem_read = 0; mem_write = 0; alu_result = res; rd_in = rd; reg_write_in = rw;
        #1 chk("alu_stall", {31'b0, stall}, 0);
        sb_q.push_back('{res, rd, rw, 1'b1});
        tick();
        chk("alu_wb_valid", {31'b0, wb_valid}, 1);
        idle_inputs();
    endtask

    task automatic mem_op(input logic rd_op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic rw,
                          input int waits, input logic [31:0] rdata, input logic [31:0] exp_wb,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int stalls = 0;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        in_valid = 1; mem_read = rd_op; mem_write = !rd_op; funct3 = f3; alu_result = addr;
        store_data = sdata; rd_in = rd; reg_write_in = rw; mem_to_reg_in = rd_op;
        #1 chk("acc_stall", {31'b0, stall}, 1);
        if (stall) stalls++;
        tick();
        chk("req", {31'b0, mem_req}, 1);
        chk("addr", mem_addr, waddr);
        chk("we", {31'b0, mem_we}, {31'b0, !rd_op});
        chk("wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
        chk("wdata", mem_wdata, exp_wdata);
        chk("acc_wb_valid", {31'b0, wb_valid}, 0);
        alu_result = 32'hFFFF_FFFF; rd_in = ~rd; store_data = ~sdata;
        for (int i = 0; i < waits; i++) begin
            mem_ready = 0;
            #1 chk("busy_stall", {31'b0, stall}, 1);
            if (stall) stalls++;
            tick();
            chk("hold_req", {31'b0, mem_req}, 1);
            chk("hold_addr", mem_addr, waddr);
            chk("hold_wdata", mem_wdata, exp_wdata);
        end
        mem_ready = 1; mem_rdata = rdata;
        #1 chk("ready_stall", {31'b0, stall}, 0);
        sb_q.push_back('{exp_wb, rd, rd_op ? (rw && rd != 5'd0) : 1'b0, rd_op});
        tick();
        mem_ready = 0; mem_rdata = 0;
        idle_inputs();
        chk("done_req", {31'b0, mem_req}, 0);
        chk("done_we", {31'b0, mem_we}, 0);
        chk("done_wstrb", {28'b0, mem_wstrb}, 0);
        chk("done_wb_valid", {31'b0, wb_valid}, 1);
        chk("stall_cycles", stalls, waits + 1);
    endtask

    task automatic bad_op(input logic rd_op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd);
        in_valid = 1; mem_read = rd_op; mem_write = !rd_op; funct3 = f3; alu_result = addr;
        rd_in = rd; reg_write_in = 1; mem_to_reg_in = rd_op; store_data = 32'h1111_2222;
        #1 chk("bad_stall", {31'b0, stall}, 0);
        sb_q.push_back('{32'h0, rd, 1'b0, 1'b0});
        tick();
        chk("bad_err", {31'b0, misalign_err}, 1);
        chk("bad_req", {31'b0, mem_req}, 0);
        idle_inputs();
        tick();
        chk("err_pulse", {31'b0, misalign_err}, 0);
        chk("bad_req2", {31'b0, mem_req}, 0);
    endtask

    initial begin
        wb_exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (wb_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("wb_unexpected", {31'b0, wb_valid}, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                    chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; mem_ready = 0; mem_rdata = 0;
        idle_inputs();
        tick();
        tick();
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_wstrb", {28'b0, mem_wstrb}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 0);
        chk("rst_wb_rw", {31'b0, wb_reg_write}, 0);
        chk("rst_err", {31'b0, misalign_err}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        rst = 0;

        alu_op(32'h0000_1234, 5'd5, 1'b1);
        tick();
        chk("idle_wb_valid", {31'b0, wb_valid}, 0);
        chk("idle_wb_rw", {31'b0, wb_reg_write}, 0);

        mem_op(1, 3'b000, 32'h103, 0, 5'd3, 1, 3, 32'h80FF_0000, 32'hFFFF_FF80, 4'b0000, 0);
        mem_op(0, 3'b001, 32'h202, 32'hABCD_1234, 5'd4, 1, 0, 0, 0, 4'b1100, 32'h1234_1234);
        bad_op(1, 3'b010, 32'h101, 5'd6);
        mem_op(1, 3'b101, 32'h002, 0, 5'd0, 1, 1, 32'h8001_0000, 32'h0000_8001, 4'b0000, 0);
        mem_op(1, 3'b001, 32'h002, 0, 5'd8, 1, 0, 32'h8001_0000, 32'hFFFF_8001, 4'b0000, 0);
        mem_op(1, 3'b010, 32'h400, 0, 5'd7, 1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 0);
        mem_op(1, 3'b100, 32'h101, 0, 5'd9, 1, 0, 32'h0000_F000, 32'h0000_00F0, 4'b0000, 0);
        mem_op(0, 3'b000, 32'h101, 32'h0000_00AB, 5'd2, 1, 0, 0, 0, 4'b0010, 32'hABAB_ABAB);
        mem_op(0, 3'b010, 32'h010, 32'hCAFE_F00D, 5'd1, 1, 1, 0, 0, 4'b1111, 32'hCAFE_F00D);
        bad_op(0, 3'b001, 32'h203, 5'd10);
        bad_op(1, 3'b011, 32'h000, 5'd11);
        bad_op(0, 3'b100, 32'h000, 5'd12);

        in_valid = 1; mem_read = 1; funct3 = 3'b010; alu_result = 32'h300;
        rd_in = 5'd9; reg_write_in = 1; mem_to_reg_in = 1;
        tick();
        chk("rb_req1", {31'b0, mem_req}, 1);
        tick();
        chk("rb_req2", {31'b0, mem_req}, 1);
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        #1;
        chk("rb_req_after", {31'b0, mem_req}, 0);
        chk("rb_stall_after", {31'b0, stall}, 0);
        chk("rb_wb_valid", {31'b0, wb_valid}, 0);
        alu_op(32'h0000_55AA, 5'd12, 1'b1);
        alu_op(32'h0000_0077, 5'd3, 1'b0);

        tick();
        tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
